// File: rtl/ov7670_fb_pkg.sv
// ov7670_fb_pkg: shared FSM state type and default frame geometry for the OV7670 frame-buffer writer
package ov7670_fb_pkg;
  typedef enum logic [1:0] {WAIT_SYNC, CAPTURE, COMMIT} state_t;
  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;
  localparam int FRAME_PIX = H_RES_DEF * V_RES_DEF;
endpackage

// File: rtl/ov7670_vsync_edge.sv
// ov7670_vsync_edge: registers v_sync once and flags its rising and falling edges
module ov7670_vsync_edge (
  input  logic pclk,
  input  logic reset,
  input  logic v_sync,
  output logic rise,
  output logic fall
);
  logic vs_d;
  always_ff @(posedge pclk or posedge reset)
    if (reset) vs_d <= 1'b0;
    else vs_d <= v_sync;
  assign rise = v_sync & ~vs_d;
  assign fall = ~v_sync & vs_d;
endmodule

// File: rtl/ov7670_fb_writer.sv
// ov7670_fb_writer: double-buffered camera frame writer; commits a bank to the display only on a good frame.
// Define FB_FRAME_CHECK_EN to require a complete, in-range frame and expose the err_cnt port.
module ov7670_fb_writer
  import ov7670_fb_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int DATA_W = 12
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              v_sync,
  input  logic              cap_we,
  input  logic [16:0]       cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              freeze,
  output logic              mem_we,
  output logic [17:0]       mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              disp_bank,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
`ifdef FB_FRAME_CHECK_EN
  ,
  output logic [7:0]        err_cnt
`endif
);
  localparam logic [16:0] frame_pix = 17'(H_RES * V_RES);
  state_t      state;
  logic        rise, fall, wr_bank, oob, good, in_range, accept;
  logic [16:0] pix_cnt;
  ov7670_vsync_edge u_edge (
    .pclk   (pclk),
    .reset  (reset),
    .v_sync (v_sync),
    .rise   (rise),
    .fall   (fall)
  );
  assign in_range = cap_addr < frame_pix;
  assign accept   = cap_we & in_range;
`ifdef FB_FRAME_CHECK_EN
  assign good = (pix_cnt == frame_pix) & ~oob;
`else
  assign good = 1'b1;
`endif
  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      state      <= WAIT_SYNC;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      disp_bank  <= 1'b0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      pix_cnt    <= '0;
      oob        <= 1'b0;
`ifdef FB_FRAME_CHECK_EN
      err_cnt    <= '0;
`endif
    end else begin
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        WAIT_SYNC:
          if (fall) begin
            state   <= CAPTURE;
            wr_bank <= ~disp_bank;
            pix_cnt <= '0;
            oob     <= 1'b0;
          end
        CAPTURE: begin
          mem_we   <= accept;
          mem_addr <= {wr_bank, cap_addr};
          mem_data <= cap_data;
          pix_cnt  <= (accept && pix_cnt != frame_pix) ? pix_cnt + 17'd1 : pix_cnt;
          oob      <= oob | (cap_we & ~in_range);
          state    <= rise ? COMMIT : CAPTURE;
        end
        COMMIT: begin
          state <= WAIT_SYNC;
          if (good && !freeze) begin
            disp_bank  <= wr_bank;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
`ifdef FB_FRAME_CHECK_EN
          if (!good && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
`endif
        end
        default: state <= WAIT_SYNC;
      endcase
    end
endmodule
